hyperbus_arbiter: RTL and testbench
===================================

# hyperbus_arbiter

Round-robin arbiter that shares the single user-side port of the Hyperbus FIFO bridge between NPORTS requesters. Accepts one read or write request at a time, issues it to the bridge as a one-cycle `rrq`/`wrq` pulse, and waits for the bridge's `rx_valid`/`tx_done` completion pulse. It then acknowledges the owning requester. Sits entirely in the user clock domain, between bus masters (CPU, DMA) and the bridge.

## Interface
- `NPORTS`, 4: number of requesters, 2..8.
- `ADDR_WIDTH`, 32: address width, equals the bridge's FIFO_ADDR_WIDTH.
- `DATA_WIDTH`, 32: data width, multiple of 8, equals the bridge's FIFO_DATA_WIDTH.

Clock, reset and requester side:
- `clk`  in  1  user clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req`  in  NPORTS  per-port request level; held until `ack` seen.
- `we`  in  NPORTS  per-port direction, 1 = write, 0 = read; stable while `req` high.
- `adr`  in  NPORTS*ADDR_WIDTH  packed addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- `wdat`  in  NPORTS*DATA_WIDTH  packed write data.
- `wmask`  in  NPORTS*DATA_WIDTH/8  packed byte masks.
- `ack`  out  NPORTS  one-cycle completion pulse to owner.
- `rdat`  out  DATA_WIDTH  read data, valid while `ack` of a read owner is high.
- `busy`  out  1  high from grant to end of DONE.

Bridge side:
- `fifo_rrq`  out  1  read request pulse.
- `fifo_wrq`  out  1  write request pulse.
- `fifo_adr`  out  ADDR_WIDTH  latched address.
- `fifo_tx_dat`  out  DATA_WIDTH  latched write data.
- `fifo_tx_mask`  out  DATA_WIDTH/8  latched mask.
- `fifo_tx_done`  in  1  write completion pulse.
- `fifo_rx_valid`  in  1  read completion pulse.
- `fifo_rx_dat`  in  DATA_WIDTH  read data, valid with `fifo_rx_valid`.

## Operation
- States: IDLE, ISSUE, WAIT, DONE (one-hot).
- **IDLE**
  - If any `req` bit is high, select the winner by round-robin starting at `ptr`.
  - Latch `owner`, `we[owner]`, `adr`, `wdat` and `wmask` of the winner.
  - Set `ptr` = (owner+1) mod NPORTS and go to ISSUE.
- **ISSUE**
  - Exactly one of `fifo_rrq`/`fifo_wrq` is high for this single cycle, selected by the latched `we`.
  - Go to WAIT.
- **WAIT**
  - For a write owner, `fifo_tx_done` ends the wait; for a read owner, `fifo_rx_valid` ends it and `fifo_rx_dat` is latched into `rdat`.
  - On that completion, pulse `ack[owner]` in the next cycle and go to DONE.
  - A completion pulse of the wrong kind is ignored.
  - There is no timeout: WAIT holds indefinitely.
- **DONE**
  - `ack[owner]` is high for this cycle. Go to IDLE.
  - During DONE, `req` from the owner is not sampled; the owner must drop `req` in the cycle after `ack`.
- Never more than one outstanding bridge request; this matches the bridge's single-transaction user FSM.
- `fifo_adr`, `fifo_tx_dat` and `fifo_tx_mask` stay stable from ISSUE through DONE.
- `rdat` holds its value until the next read completes.

## Timing
- Reset values:
  - `ack`, `fifo_rrq`, `fifo_wrq` and `busy` are 0.
  - `rdat`, `fifo_adr`, `fifo_tx_dat` and `fifo_tx_mask` are 0.
  - `ptr` = 0; state IDLE.
- Latency: `req` sampled high at edge t → `fifo_*rq` high in cycle t+1 → bridge completion at edge w → `ack` high in cycle w+1.
- Minimum turnaround between grants is 4 cycles (IDLE, ISSUE, WAIT≥1, DONE).
- Requests with simultaneous `req` bits are served in rotating order, so with all ports requesting, each port is served once every NPORTS transactions.
- `ptr` wraps from NPORTS-1 to 0.
- A port dropping `req` before its grant is simply skipped; requests are never queued internally.
- Reset mid-transaction aborts it: no `ack` is issued, and the bridge must be reset in the same event.

## Configuration
- `HYPERBUS_ARB_PRIO0_EN` defined: port 0 has fixed highest priority. It wins whenever `req[0]` is high in IDLE. Ports 1..NPORTS-1 rotate among themselves, and `ptr` is updated only on their grants.
- `HYPERBUS_ARB_PRIO0_EN` undefined: pure round-robin over all ports.

## Structure
- Shared package `hyperbus_pkg`: state encodings (ARB_IDLE/ISSUE/WAIT/DONE) and the CMD_READ/CMD_WRITE direction constants.
- One sub-module, `hyperbus_rr_pick`, is natural. It is combinational and takes `req`, `ptr` and the priority mode, and outputs the winner index and a `found` flag.
- Packed vector slicing and latching stay in the top module.

## Test plan
- Single write: port 2 sends adr 0x100, wdat 0xDEADBEEF, wmask 0xF. Expected: `fifo_wrq` is pulsed once with those values; `tx_done` 5 cycles later → `ack[2]` the next cycle; other `ack` bits stay 0.
- Single read: port 1 reads adr 0x40; the bridge returns 0x12345678 with `fifo_rx_valid`. Expected: `rdat` = 0x12345678 while `ack[1]` is high.
- All four ports hold `req` from reset. Expected grant order is 0,1,2,3,0, and no `fifo_*rq` is issued during WAIT.
- Wrong-kind completion: a `fifo_tx_done` during a read WAIT is ignored; the state stays WAIT until `fifo_rx_valid`.
- With `HYPERBUS_ARB_PRIO0_EN`: ports 0 and 3 both request continuously. Expected: port 0 wins every grant; port 3 is granted once port 0 drops `req`.
- Reset mid-operation: assert `rst_n`=0 during WAIT. Expected: outputs return to their reset values immediately, no `ack` is issued, and the next grant after reset goes to port 0.

Source files
------------

// File: rtl/hyperbus_pkg.sv
// Shared definitions for the Hyperbus arbiter: FSM state encoding and command direction.
package hyperbus_pkg;

    typedef enum logic [3:0] {
        ARB_IDLE  = 4'b0001,
        ARB_ISSUE = 4'b0010,
        ARB_WAIT  = 4'b0100,
        ARB_DONE  = 4'b1000
    } arb_state_e;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

endpackage

// File: rtl/hyperbus_rr_pick.sv
// Combinational round-robin winner search starting at ptr; optional fixed priority for port 0.
module hyperbus_rr_pick #(
    parameter int NPORTS = 4,
    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
    input  logic [NPORTS-1:0] req,
    input  logic [PW-1:0]     ptr,
    input  logic              prio0,
    output logic [PW-1:0]     win,
    output logic              found
);

    logic [NPORTS-1:0] eligible;
    int                idx;

    always_comb begin
        win      = '0;
        found    = 1'b0;
        idx      = 0;
        eligible = req;
        // In priority mode port 0 never takes part in the rotation.
        if (prio0) eligible[0] = 1'b0;
        if (prio0 && req[0]) begin
            found = 1'b1;
        end else begin
            for (int k = 0; k < NPORTS; k++) begin
                idx = (int'(ptr) + k) % NPORTS;
                if (!found && eligible[idx]) begin
                    found = 1'b1;
                    win   = PW'(idx);
                end
            end
        end
    end

endmodule

// File: rtl/hyperbus_arbiter.sv
// Round-robin arbiter sharing the Hyperbus bridge user port; one outstanding request at a time.
// Define HYPERBUS_ARB_PRIO0_EN to give port 0 fixed highest priority.
module hyperbus_arbiter
    import hyperbus_pkg::*;
#(
    parameter int NPORTS     = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NPORTS-1:0]              req,
    input  logic [NPORTS-1:0]              we,
    input  logic [NPORTS*ADDR_WIDTH-1:0]   adr,
    input  logic [NPORTS*DATA_WIDTH-1:0]   wdat,
    input  logic [NPORTS*DATA_WIDTH/8-1:0] wmask,
    output logic [NPORTS-1:0]              ack,
    output logic [DATA_WIDTH-1:0]          rdat,
    output logic                           busy,
    output logic                           fifo_rrq,
    output logic                           fifo_wrq,
    output logic [ADDR_WIDTH-1:0]          fifo_adr,
    output logic [DATA_WIDTH-1:0]          fifo_tx_dat,
    output logic [DATA_WIDTH/8-1:0]        fifo_tx_mask,
    input  logic                           fifo_tx_done,
    input  logic                           fifo_rx_valid,
    input  logic [DATA_WIDTH-1:0]          fifo_rx_dat
);

    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int MW = DATA_WIDTH / 8;
`ifdef HYPERBUS_ARB_PRIO0_EN
    localparam logic PRIO0 = 1'b1;
`else
    localparam logic PRIO0 = 1'b0;
`endif

    arb_state_e    state;
    logic [PW-1:0] ptr, owner, win;
    logic          dir, found, complete;

    hyperbus_rr_pick #(.NPORTS(NPORTS)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .prio0 (PRIO0),
        .win   (win),
        .found (found)
    );

    // Only the completion kind matching the latched direction ends WAIT.
    assign complete = (dir == CMD_WRITE) ? fifo_tx_done : fifo_rx_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ARB_IDLE;
            ptr          <= '0;
            owner        <= '0;
            dir          <= CMD_READ;
            ack          <= '0;
            rdat         <= '0;
            busy         <= 1'b0;
            fifo_rrq     <= 1'b0;
            fifo_wrq     <= 1'b0;
            fifo_adr     <= '0;
            fifo_tx_dat  <= '0;
            fifo_tx_mask <= '0;
        end else begin
            case (state)
                ARB_IDLE: if (found) begin
                    owner        <= win;
                    dir          <= we[win];
                    fifo_adr     <= adr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
                    fifo_tx_dat  <= wdat[int'(win)*DATA_WIDTH +: DATA_WIDTH];
                    fifo_tx_mask <= wmask[int'(win)*MW +: MW];
                    fifo_wrq     <= (we[win] == CMD_WRITE);
                    fifo_rrq     <= (we[win] == CMD_READ);
                    busy         <= 1'b1;
                    // A priority grant to port 0 leaves the rotation untouched.
                    if (!(PRIO0 && win == '0))
                        ptr <= (int'(win) == NPORTS-1) ? '0 : win + PW'(1);
                    state        <= ARB_ISSUE;
                end
                ARB_ISSUE: begin
                    fifo_wrq <= 1'b0;
                    fifo_rrq <= 1'b0;
                    state    <= ARB_WAIT;
                end
                ARB_WAIT: if (complete) begin
                    if (dir == CMD_READ) rdat <= fifo_rx_dat;
                    ack[owner] <= 1'b1;
                    state      <= ARB_DONE;
                end
                ARB_DONE: begin
                    ack   <= '0;
                    busy  <= 1'b0;
                    state <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hyperbus_arbiter.sv
// Scoreboard bench for hyperbus_arbiter: stimulus pushes expected issues/acks, a negedge monitor checks them.
module tb_hyperbus_arbiter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req = '0, we = '0, ack;
    logic [127:0] adr = '0, wdat = '0;
    logic [15:0]  wmask = '0;
    logic [31:0]  rdat, fifo_adr, fifo_tx_dat, fifo_rx_dat = '0;
    logic [3:0]   fifo_tx_mask;
    logic         busy, fifo_rrq, fifo_wrq;
    logic         fifo_tx_done = 1'b0, fifo_rx_valid = 1'b0;

    hyperbus_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .adr(adr), .wdat(wdat), .wmask(wmask),
        .ack(ack), .rdat(rdat), .busy(busy), .fifo_rrq(fifo_rrq), .fifo_wrq(fifo_wrq),
        .fifo_adr(fifo_adr), .fifo_tx_dat(fifo_tx_dat), .fifo_tx_mask(fifo_tx_mask),
        .fifo_tx_done(fifo_tx_done), .fifo_rx_valid(fifo_rx_valid), .fifo_rx_dat(fifo_rx_dat)
    );

    always #5 clk = ~clk;

    typedef struct { logic w; logic [31:0] adr, dat; logic [3:0] mask; int cyc; } iss_t;
    typedef struct { logic [3:0] ack; logic [31:0] rdat; int cyc; } ack_t;

    iss_t        iss_q[$];
    ack_t        ack_q[$];
    int          checks = 0, errors = 0, cyc = 0;
    logic        outstanding = 1'b0;
    logic [31:0] saved_adr = '0, last_rd = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the heads of the expectation queues.
    always @(negedge clk) begin
        if (!rst_n) begin
            outstanding = 1'b0;
        end else begin
            if (fifo_rrq || fifo_wrq) begin
                iss_t e;
                chk("rq_while_outstanding", {31'd0, outstanding}, 32'd0);
                chk("busy_at_issue", {31'd0, busy}, 32'd1);
                if (iss_q.size() == 0) begin
                    chk("unexpected_rq", 32'd1, 32'd0);
                end else begin
                    e = iss_q.pop_front();
                    chk("rq_kind", {30'd0, fifo_wrq, fifo_rrq}, {30'd0, e.w, ~e.w});
                    chk("fifo_adr", fifo_adr, e.adr);
                    chk("fifo_tx_dat", fifo_tx_dat, e.dat);
                    chk("fifo_tx_mask", {28'd0, fifo_tx_mask}, {28'd0, e.mask});
                    if (e.cyc >= 0) chk("rq_cycle", cyc, e.cyc);
                end
                outstanding = 1'b1;
                saved_adr   = fifo_adr;
            end
            if (ack != '0) begin
                ack_t a;
                if (ack_q.size() == 0) begin
                    chk("unexpected_ack", {28'd0, ack}, 32'd0);
                end else begin
                    a = ack_q.pop_front();
                    chk("ack_vec", {28'd0, ack}, {28'd0, a.ack});
                    chk("rdat", rdat, a.rdat);
                    chk("ack_cycle", cyc, a.cyc);
                    chk("fifo_adr_stable", fifo_adr, saved_adr);
                end
                outstanding = 1'b0;
            end
        end
    end

    task automatic set_port(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] m);
        we[p] = w;
        adr[p*32 +: 32] = a;
        wdat[p*32 +: 32] = d;
        wmask[p*4 +: 4] = m;
    endtask

    // Bridge model: wait for the request pulse, delay, optionally send a wrong-kind pulse, then complete.
    task automatic serve(input int p, input logic w, input logic [31:0] rd, input int dly, input bit wrong);
        ack_t a;
        int   n = 0;
        while (!(fifo_rrq || fifo_wrq) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("rq_timeout", 32'd1, 32'd0);
        repeat (dly) @(negedge clk);
        if (wrong) begin
            if (w) fifo_rx_valid = 1'b1; else fifo_tx_done = 1'b1;
            fifo_rx_dat = 32'hBADBAD00;
            @(negedge clk);
            fifo_rx_valid = 1'b0;
            fifo_tx_done  = 1'b0;
            repeat (3) @(negedge clk);
        end
        if (w) fifo_tx_done = 1'b1;
        else begin
            fifo_rx_valid = 1'b1;
            last_rd = rd;
        end
        fifo_rx_dat = rd;
        a.ack = 4'b0001 << p;
        a.rdat = last_rd;
        a.cyc = cyc + 1;
        ack_q.push_back(a);
        @(negedge clk);
        fifo_tx_done  = 1'b0;
        fifo_rx_valid = 1'b0;
        fifo_rx_dat   = 32'hBADBAD00;
    endtask

    task automatic push_iss(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] m, input int c);
        iss_t e;
        e.w = w; e.adr = a; e.dat = d; e.mask = m; e.cyc = c;
        iss_q.push_back(e);
    endtask

    task automatic txn(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, input logic [31:0] rd, input int dly, input bit wrong);
        @(negedge clk);
        set_port(p, w, a, d, m);
        req[p] = 1'b1;
        push_iss(w, a, d, m, cyc + 1);
        @(negedge clk);
        serve(p, w, rd, dly, wrong);
        req[p] = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ack"}, {28'd0, ack}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_rq"}, {30'd0, fifo_rrq, fifo_wrq}, 32'd0);
        chk({tag, "_rdat"}, rdat, 32'd0);
        chk({tag, "_fifo_adr"}, fifo_adr, 32'd0);
        chk({tag, "_tx_dat"}, fifo_tx_dat, 32'd0);
        chk({tag, "_tx_mask"}, {28'd0, fifo_tx_mask}, 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single write on port 2, completion 5 cycles after the request pulse.
        txn(2, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 32'h0, 5, 1'b0);
        // Single read on port 1.
        txn(1, 1'b0, 32'h40, 32'h0, 4'h3, 32'h12345678, 2, 1'b0);
        // Read on port 3 with a stray tx_done during WAIT.
        txn(3, 1'b0, 32'h80, 32'h11, 4'h1, 32'hCAFEF00D, 1, 1'b1);
        // Write after reads: rdat must still hold the last read value.
        txn(0, 1'b1, 32'hC0, 32'h55AA55AA, 4'h5, 32'h0, 1, 1'b0);

`ifdef HYPERBUS_ARB_PRIO0_EN
        // Ports 0 and 3 both request: port 0 keeps winning until it drops.
        @(negedge clk);
        set_port(0, 1'b1, 32'h300, 32'hA0, 4'hF);
        set_port(3, 1'b1, 32'h330, 32'hA3, 4'hE);
        req = 4'b1001;
        push_iss(1'b1, 32'h300, 32'hA0, 4'hF, -1);
        push_iss(1'b1, 32'h300, 32'hA0, 4'hF, -1);
        push_iss(1'b1, 32'h330, 32'hA3, 4'hE, -1);
        @(negedge clk);
        serve(0, 1'b1, 32'h0, 2, 1'b0);
        serve(0, 1'b1, 32'h0, 2, 1'b0);
        req[0] = 1'b0;
        serve(3, 1'b1, 32'h0, 2, 1'b0);
        req = '0;
        repeat (2) @(negedge clk);
`else
        // All ports requesting after a fresh reset: grants 0,1,2,3,0.
        rst_n = 1'b0;
        last_rd = '0;
        @(negedge clk);
        for (int p = 0; p < 4; p++) set_port(p, 1'b1, 32'h1000 + p, 32'hD0 + p, 4'(p + 1));
        req = 4'hF;
        rst_n = 1'b1;
        for (int p = 0; p < 5; p++) push_iss(1'b1, 32'h1000 + (p % 4), 32'hD0 + (p % 4), 4'((p % 4) + 1), -1);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            serve(k % 4, 1'b1, 32'h0, 2, 1'b0);
            if (k == 4) req = '0;
        end
        repeat (2) @(negedge clk);
`endif

        // Reset during a read WAIT on port 2 (ptr would otherwise point at 3).
        @(negedge clk);
        set_port(2, 1'b0, 32'h200, 32'h22, 4'h2);
        req[2] = 1'b1;
        push_iss(1'b0, 32'h200, 32'h22, 4'h2, cyc + 1);
        @(negedge clk);
        for (int n = 0; n < 40 && !(fifo_rrq || fifo_wrq); n++) @(negedge clk);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        req = '0;
        last_rd = '0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        chk("midrst_no_ack", {28'd0, ack}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        set_port(0, 1'b1, 32'h400, 32'hB0, 4'h9);
        set_port(3, 1'b1, 32'h430, 32'hB3, 4'h6);
        req = 4'b1001;
        push_iss(1'b1, 32'h400, 32'hB0, 4'h9, cyc + 1);
        @(negedge clk);
        serve(0, 1'b1, 32'h0, 1, 1'b0);
        req = '0;
        repeat (4) @(negedge clk);

        chk("iss_q_drained", iss_q.size(), 32'd0);
        chk("ack_q_drained", ack_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
